// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program-counter sequencer for instruction fetch.
// The next PC comes from increment, PC-relative branch, absolute call or
// return. Return addresses live in a small circular LIFO. When the LIFO is
// full, a further call overwrites the oldest entry. Misuse of the stack
// raises sticky overflow/underflow flags.
module pc_sequencer #(
  parameter int ADDR_W   = 6,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall,
  input  logic                    ret_en,
  input  logic                    call_en,
  input  logic [ADDR_W-1:0]       call_target,
  input  logic                    branch_en,
  input  logic [ADDR_W-1:0]       branch_off,
  input  logic                    clr_flags,
  output logic [ADDR_W-1:0]       pc,
  output logic [$clog2(DEPTH):0]  depth,
  output logic                    stk_overflow,
  output logic                    stk_underflow
);

  // Pointer width: DEPTH is a power of two, so the pointer wraps naturally.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_INIT  = ADDR_W'(RESET_PC);

  logic [ADDR_W-1:0] r_pc;
  logic [CNT_W-1:0]  r_depth;
  logic [PTR_W-1:0]  r_wr_ptr;   // slot the next push writes; top is r_wr_ptr-1
  logic              r_ovf;
  logic              r_unf;
  logic [ADDR_W-1:0] r_stack [DEPTH];

  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [CNT_W-1:0]  w_depth_next;
  logic [PTR_W-1:0]  w_ptr_next;
  logic [PTR_W-1:0]  w_top_ptr;
  logic              w_push;
  logic              w_ovf_set;
  logic              w_unf_set;

  // Next-state selection: stall > ret > call > branch > increment.
  always_comb begin
    w_pc_inc     = r_pc + ADDR_W'(1);
    w_top_ptr    = r_wr_ptr - PTR_W'(1);
    w_pc_next    = r_pc;
    w_depth_next = r_depth;
    w_ptr_next   = r_wr_ptr;
    w_push       = 1'b0;
    w_ovf_set    = 1'b0;
    w_unf_set    = 1'b0;
    if (!stall) begin
      if (ret_en) begin
        if (r_depth != '0) begin
          w_pc_next    = r_stack[w_top_ptr];
          w_depth_next = r_depth - CNT_W'(1);
          w_ptr_next   = w_top_ptr;
        end else begin
          // Empty-stack return: flag it and fall through to the next address.
          w_unf_set = 1'b1;
          w_pc_next = w_pc_inc;
        end
      end else if (call_en) begin
        // A full stack still accepts the push. The circular write overwrites
        // the oldest entry, so depth saturates at DEPTH.
        w_push     = 1'b1;
        w_pc_next  = call_target;
        w_ptr_next = r_wr_ptr + PTR_W'(1);
        if (r_depth == FULL_CNT) begin
          w_ovf_set = 1'b1;
        end else begin
          w_depth_next = r_depth + CNT_W'(1);
        end
      end else if (branch_en) begin
        w_pc_next = r_pc + branch_off;
      end else begin
        w_pc_next = w_pc_inc;
      end
    end
  end

  // PC, depth, pointer and sticky flags; reset discards all stack state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc     <= PC_INIT;
      r_depth  <= '0;
      r_wr_ptr <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_pc     <= w_pc_next;
      r_depth  <= w_depth_next;
      r_wr_ptr <= w_ptr_next;
      // A new error in the same cycle as a clear request leaves the flag set.
      r_ovf    <= (r_ovf & ~clr_flags) | w_ovf_set;
      r_unf    <= (r_unf & ~clr_flags) | w_unf_set;
    end
  end

  // Return-address storage; contents need no reset because depth gates reads.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_stack[r_wr_ptr] <= w_pc_inc;
    end
  end

  assign pc            = r_pc;
  assign depth         = r_depth;
  assign stk_overflow  = r_ovf;
  assign stk_underflow = r_unf;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Registered 6-bit program-counter sequencer for the instruction-fetch stage. Each cycle it selects the next PC from one of: increment, PC-relative branch, absolute call, or return.
- Calls push the return address (PC+1) onto an internal LIFO.
- Returns pop that address and restore it, so returns are the inverse of calls.
- It is the stateful consumer of the PC-increment/offset arithmetic.

Parameters:
- ADDR_W, 6, PC width in bits; all PC arithmetic is modulo 2^ADDR_W.
- DEPTH, 4, return-stack entries; must be a power of 2.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- stall  input  1  hold all state this cycle.
- ret_en  input  1  pop the return stack and jump to the popped address.
- call_en  input  1  push PC+1 and jump to call_target.
- call_target  input  ADDR_W  absolute call destination.
- branch_en  input  1  PC-relative branch.
- branch_off  input  ADDR_W  two's-complement branch offset.
- clr_flags  input  1  clear the sticky error flags.
- pc  output  ADDR_W  current fetch address (registered).
- depth  output  log2(DEPTH)+1  number of valid stack entries.
- stk_overflow  output  1  sticky flag: a call was made with the stack full.
- stk_underflow  output  1  sticky flag: a return was made with the stack empty.

Behaviour:
- Single clock domain. Reset is synchronous and active-low: rst_n sampled low at a rising edge of clk resets the block, with priority over every other input.
- Reset values: pc=RESET_PC, depth=0, stk_overflow=0, stk_underflow=0. Stack contents are don't-care and are never read while depth=0.
- Reset mid-operation (asserted during any call, return or stall) discards all stack state. The cycle after rst_n goes high, pc=RESET_PC.
- One-cycle latency: control inputs sampled at edge N determine pc after edge N. pc is never combinationally driven from inputs.
- Next-PC priority, highest first: stall > ret_en > call_en > branch_en > increment.
  - stall=1: pc, stack and depth hold. clr_flags is still honoured.
  - ret_en, depth>0: pc <= top entry; depth <= depth-1.
  - ret_en, depth=0: stk_underflow <= 1; pc <= pc+1; depth stays 0.
  - call_en, depth<DEPTH: push (pc+1) mod 2^ADDR_W; depth <= depth+1; pc <= call_target.
  - call_en, depth=DEPTH: stk_overflow <= 1. The oldest entry is discarded, the new entry becomes top, depth stays DEPTH, and pc <= call_target. Implement the stack as circular storage with a top pointer.
  - branch_en: pc <= (pc + branch_off) mod 2^ADDR_W. Carry-out is discarded. Negative offsets wrap (e.g. 2 + 0x3E = 0).
  - Otherwise: pc <= pc+1, wrapping 63 -> 0.
- A lower-priority request asserted in the same cycle as a higher one is ignored, not queued.
- The pushed return address wraps: a call at pc=63 pushes 0.
- Sticky flags:
  - Set on error and remain set until reset or clr_flags=1.
  - If clr_flags and a new error occur in the same cycle, set wins.
- depth never exceeds DEPTH and never underflows below 0.

Test Plan:
- Reset and increment: hold rst_n=0 for 2 cycles, then release with no requests. Required: pc=0,1,2,… and wraps 63 -> 0 after 64 cycles; depth=0; both flags 0.
- Branch arithmetic:
  - pc=10, branch_off=0x05 -> pc=15.
  - pc=2, branch_off=0x3E (-2) -> pc=0.
  - pc=60, branch_off=0x08 -> pc=4.
- Call/return nesting: at pc=5, call 0x20, then at 0x21 call 0x30, then ret, then ret. Required: pc sequence 0x20, 0x21, 0x30, 0x22, 6; depth sequence 1, 1, 2, 1, 0.
- Overflow with DEPTH=4: perform 5 consecutive calls from pc=1 to targets 10, 20, 30, 40, 50. Required:
  - stk_overflow=1 after the 5th call and depth=4.
  - Four rets return 41, 31, 21, 11; the 5th ret sets stk_underflow and gives pc=12.
- Priority and stall:
  - stall=1 together with call_en: pc and depth unchanged.
  - ret_en+call_en+branch_en together with depth=1: only the pop occurs.
  - clr_flags during stall clears both flags.
- Reset mid-operation: with depth=3 and pc=0x30, assert rst_n=0 together with call_en. Required: the next cycle shows pc=0 and depth=0, and a following ret sets stk_underflow.
